pio_poll_master: RTL and testbench

- Avalon-MM read initiator that periodically polls an 8-bit input PIO slave (switch port, data register at word address 0, registered readdata, fixed read latency).
- Debounces successive samples and publishes a stable switch vector plus one-cycle rise/fall edge masks to fabric logic, e.g. game control FSMs.
- Lets hardware consume switch state without the soft CPU polling it.

---
 rtl/pio_poll_pkg.sv | 19 +
 rtl/pio_debounce.sv | 82 ++++++++
 rtl/pio_poll_master.sv | 116 +++++++++++
 tb/tb_pio_poll_master.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pio_poll_pkg.sv
// Shared types and constants for the PIO polling master and its debouncer.
package pio_poll_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_LAT  = 2'd2,
    ST_UPD  = 2'd3
  } poll_state_e;

  localparam logic [1:0] PIO_DATA_ADDR = 2'd0;

  localparam int POLL_PERIOD_MIN  = 4;
  localparam int READ_LATENCY_MIN = 1;
  localparam int READ_LATENCY_MAX = 4;
  localparam int DEBOUNCE_N_MIN   = 1;
  localparam int DEBOUNCE_N_MAX   = 15;

endpackage

// File: rtl/pio_debounce.sv
// Debounces a strobed sample stream into a stable vector with one-cycle edge masks.
module pio_debounce #(
  parameter int DATA_W     = 8,
  parameter int DEBOUNCE_N = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              sample_stb,
  input  logic [DATA_W-1:0] sample_data,
  output logic [DATA_W-1:0] stable,
  output logic              valid,
  output logic              change,
  output logic [DATA_W-1:0] rise,
  output logic [DATA_W-1:0] fall
);

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] CNT_SAT = CNT_W'(DEBOUNCE_N);

  logic [DATA_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] stable_q, stable_d;
  logic              valid_q, valid_d;
  logic              change_q, change_d;
  logic [DATA_W-1:0] rise_q, rise_d;
  logic [DATA_W-1:0] fall_q, fall_d;

  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    valid_d  = valid_q;
    change_d = 1'b0;
    rise_d   = '0;
    fall_d   = '0;
    if (sample_stb) begin
      if (sample_data == cand_q) begin
        cnt_d = (cnt_q >= CNT_SAT) ? CNT_SAT : cnt_q + 1'b1;
      end else begin
        cand_d = sample_data;
        cnt_d  = CNT_W'(1);
      end
      // The very first load only seeds the vector; edges are reported from then on.
      if (cnt_d == CNT_SAT && (cand_d != stable_q || !valid_q)) begin
        stable_d = cand_d;
        valid_d  = 1'b1;
        if (valid_q) begin
          change_d = 1'b1;
          rise_d   = cand_d & ~stable_q;
          fall_d   = ~cand_d & stable_q;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cand_q   <= '0;
      cnt_q    <= '0;
      stable_q <= '0;
      valid_q  <= 1'b0;
      change_q <= 1'b0;
      rise_q   <= '0;
      fall_q   <= '0;
    end else begin
      cand_q   <= cand_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      valid_q  <= valid_d;
      change_q <= change_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign stable = stable_q;
  assign valid  = valid_q;
  assign change = change_q;
  assign rise   = rise_q;
  assign fall   = fall_q;

endmodule

// File: rtl/pio_poll_master.sv
// Avalon-MM read initiator that periodically samples a switch PIO and debounces it.
// avm_read is high exactly while the FSM sits in REQ; state_q is the FSM observation point.
module pio_poll_master
  import pio_poll_pkg::*;
#(
  parameter int POLL_PERIOD  = 50000,
  parameter int READ_LATENCY = 1,
  parameter int DEBOUNCE_N   = 4,
  parameter int DATA_W       = 8
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [1:0]        avm_address,
  output logic              avm_read,
  input  logic              avm_waitrequest,
  input  logic [31:0]       avm_readdata,
  output logic [DATA_W-1:0] sw_stable,
  output logic              sw_valid,
  output logic              sw_change,
  output logic [DATA_W-1:0] sw_rise,
  output logic [DATA_W-1:0] sw_fall
);

  localparam int PCNT_W = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int LCNT_W = 2;
  localparam logic [PCNT_W-1:0] PERIOD_LAST = PCNT_W'(POLL_PERIOD - 1);
  localparam logic [LCNT_W-1:0] LAT_LAST    = LCNT_W'(READ_LATENCY - 1);

  poll_state_e       state_q, state_d;
  logic [PCNT_W-1:0] period_q, period_d;
  logic [LCNT_W-1:0] lat_q, lat_d;
  logic [DATA_W-1:0] sample_q, sample_d;
  logic              sample_stb;

  generate
    if (DATA_W < 32) begin : g_unused_hi
      logic unused_readdata_hi;
      assign unused_readdata_hi = ^avm_readdata[31:DATA_W];
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    period_d   = period_q;
    lat_d      = lat_q;
    sample_d   = sample_q;
    sample_stb = 1'b0;
    avm_read   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (!enable) begin
          period_d = '0;
        end else if (period_q == PERIOD_LAST) begin
          period_d = '0;
          state_d  = ST_REQ;
        end else begin
          period_d = period_q + 1'b1;
        end
      end
      ST_REQ: begin
        // Request is held with a stable address until the slave accepts it.
        avm_read = 1'b1;
        if (!avm_waitrequest) begin
          lat_d   = '0;
          state_d = ST_LAT;
        end
      end
      ST_LAT: begin
        if (lat_q == LAT_LAST) begin
          sample_d = avm_readdata[DATA_W-1:0];
          state_d  = ST_UPD;
        end else begin
          lat_d = lat_q + 1'b1;
        end
      end
      ST_UPD: begin
        sample_stb = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      period_q <= '0;
      lat_q    <= '0;
      sample_q <= '0;
    end else begin
      state_q  <= state_d;
      period_q <= period_d;
      lat_q    <= lat_d;
      sample_q <= sample_d;
    end
  end

  assign avm_address = PIO_DATA_ADDR;

  pio_debounce #(
    .DATA_W    (DATA_W),
    .DEBOUNCE_N(DEBOUNCE_N)
  ) u_debounce (
    .clk        (clk),
    .reset_n    (reset_n),
    .sample_stb (sample_stb),
    .sample_data(sample_q),
    .stable     (sw_stable),
    .valid      (sw_valid),
    .change     (sw_change),
    .rise       (sw_rise),
    .fall       (sw_fall)
  );

endmodule

// File: tb/tb_pio_poll_master.sv
// Self-checking bench for pio_poll_master: bench-side PIO slave, debounce model and edge scoreboard.
module tb_pio_poll_master;

  localparam int POLL_PERIOD  = 8;
  localparam int READ_LATENCY = 1;
  localparam int DEBOUNCE_N   = 4;
  localparam int DATA_W       = 8;
  localparam int EW           = 3 * DATA_W;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              enable;
  logic [1:0]        avm_address;
  logic              avm_read;
  logic              avm_waitrequest;
  logic [31:0]       avm_readdata;
  logic [DATA_W-1:0] sw_stable;
  logic              sw_valid;
  logic              sw_change;
  logic [DATA_W-1:0] sw_rise;
  logic [DATA_W-1:0] sw_fall;

  pio_poll_master #(
    .POLL_PERIOD (POLL_PERIOD),
    .READ_LATENCY(READ_LATENCY),
    .DEBOUNCE_N  (DEBOUNCE_N),
    .DATA_W      (DATA_W)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .enable         (enable),
    .avm_address    (avm_address),
    .avm_read       (avm_read),
    .avm_waitrequest(avm_waitrequest),
    .avm_readdata   (avm_readdata),
    .sw_stable      (sw_stable),
    .sw_valid       (sw_valid),
    .sw_change      (sw_change),
    .sw_rise        (sw_rise),
    .sw_fall        (sw_fall)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    #300000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model + scoreboard ----------------
  logic [EW-1:0]     exp_q[$];
  logic [DATA_W-1:0] m_cand, m_stable;
  int                m_cnt;
  logic              m_valid;

  task automatic model_reset();
    m_cand = '0; m_stable = '0; m_cnt = 0; m_valid = 1'b0;
    exp_q.delete();
  endtask

  task automatic model_sample(input logic [DATA_W-1:0] s);
    if (s == m_cand) begin
      if (m_cnt < DEBOUNCE_N) m_cnt++;
    end else begin
      m_cand = s;
      m_cnt  = 1;
    end
    if (m_cnt == DEBOUNCE_N && (m_cand != m_stable || !m_valid)) begin
      if (m_valid) exp_q.push_back({m_cand, m_cand & ~m_stable, ~m_cand & m_stable});
      m_stable = m_cand;
      m_valid  = 1'b1;
    end
  endtask

  // ---------------- bench-side PIO slave ----------------
  logic [DATA_W-1:0] slave_data = '0;
  int stall_left = 0, stall_addr_ok = 0, cur_hi = 0, last_hi = 0;
  int accept_cnt = 0, polls_done = 0;

  initial forever begin
    logic [DATA_W-1:0] v;
    logic [31:0]       rd;
    @(negedge clk);
    if (!reset_n) begin
      cur_hi = 0;
    end else if (avm_read) begin
      cur_hi++;
      if (stall_left > 0) begin
        avm_waitrequest = 1'b1;
        stall_left--;
        if (avm_address == 2'd0) stall_addr_ok++;
      end else begin
        avm_waitrequest = 1'b0;
        last_hi = cur_hi;
        cur_hi  = 0;
        accept_cnt++;
        @(posedge clk);
        repeat (READ_LATENCY - 1) @(posedge clk);
        #1;
        v  = slave_data;
        rd = $urandom;
        rd[DATA_W-1:0] = v;
        avm_readdata = rd;
        @(posedge clk);
        #1 avm_readdata = $urandom;
        if (reset_n) begin
          polls_done++;
          model_sample(v);
        end
      end
    end
  end

  // ---------------- monitors ----------------
  int   launch_cnt = 0, last_launch = 0, last_interval = 0, change_cnt = 0;
  logic prev_read = 1'b0, prev_change = 1'b0;

  initial forever begin
    @(negedge clk);
    if (!reset_n) begin
      prev_read   = 1'b0;
      prev_change = 1'b0;
    end else begin
      if (avm_read && !prev_read) begin
        launch_cnt++;
        last_interval = cyc - last_launch;
        last_launch   = cyc;
      end
      prev_read = avm_read;
      if (sw_change) begin
        change_cnt++;
        if (exp_q.size() == 0) check("unexpected_change", 32'(sw_change), 32'd0);
        else check("edge_vector", 32'({sw_stable, sw_rise, sw_fall}), 32'(exp_q.pop_front()));
      end else if (prev_change) begin
        check("pulse_end_rise_fall", 32'({sw_rise, sw_fall}), 32'd0);
      end
      prev_change = sw_change;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_polls(input int n);
    int target = polls_done + n;
    int t = 0;
    while (polls_done < target && t < 300 * n) begin
      @(posedge clk);
      t++;
    end
    if (polls_done < target) check("poll_timeout", 32'(polls_done), 32'(target));
    @(negedge clk);
    #1;
  endtask

  task automatic wait_launch(input int target);
    int t = 0;
    while (launch_cnt < target && t < 400) begin
      @(posedge clk);
      t++;
    end
    if (launch_cnt < target) check("launch_timeout", 32'(launch_cnt), 32'(target));
  endtask

  task automatic check_outputs_reset(input string tag);
    check({tag, "_read"},   32'(avm_read),  32'd0);
    check({tag, "_addr"},   32'(avm_address), 32'd0);
    check({tag, "_stable"}, 32'(sw_stable), 32'd0);
    check({tag, "_valid"},  32'(sw_valid),  32'd0);
    check({tag, "_edges"},  32'({sw_change, sw_rise, sw_fall}), 32'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c0, lc, i1, i2, p0, chg0;
    reset_n = 1'b0; enable = 1'b0;
    avm_waitrequest = 1'b0; avm_readdata = $urandom;
    model_reset();
    repeat (3) @(posedge clk);
    #1 check_outputs_reset("reset");
    @(negedge clk) reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // first launch POLL_PERIOD cycles after enable
    enable = 1'b1; c0 = cyc;
    wait_launch(1);
    check("first_launch_delay", 32'(last_launch - c0), 32'(POLL_PERIOD));

    // four samples of zero: first load, no change pulse
    slave_data = 8'h00;
    wait_polls(4);
    check("first_load_valid",  32'(sw_valid),  32'd1);
    check("first_load_stable", 32'(sw_stable), 32'h00);
    check("first_load_nochg",  32'(change_cnt), 32'd0);

    // 0x05 held
    slave_data = 8'h05;
    wait_polls(4);
    check("held05_stable", 32'(sw_stable), 32'h05);
    check("held05_pulses", 32'(change_cnt), 32'd1);

    // toggling never reaches the debounce threshold
    for (int i = 0; i < 6; i++) begin
      slave_data = (i % 2 == 0) ? 8'h07 : 8'h05;
      wait_polls(1);
    end
    check("toggle_stable", 32'(sw_stable), 32'h05);
    check("toggle_pulses", 32'(change_cnt), 32'd1);

    // 0x03 held
    slave_data = 8'h03;
    wait_polls(4);
    check("held03_stable", 32'(sw_stable), 32'h03);
    check("held03_pulses", 32'(change_cnt), 32'd2);

    // random held values, each held long enough to settle
    for (int i = 0; i < 3; i++) begin
      slave_data = 8'($urandom_range(0, 255));
      wait_polls(DEBOUNCE_N + 1);
      check("rand_stable", 32'(sw_stable), 32'(slave_data));
    end

    // six-cycle waitrequest stall on one poll
    stall_left = 6; stall_addr_ok = 0; lc = launch_cnt;
    wait_launch(lc + 1);
    i1 = last_interval;
    wait_polls(1);
    check("stall_read_cycles", 32'(last_hi), 32'd7);
    check("stall_addr_stable", 32'(stall_addr_ok), 32'd6);
    wait_launch(lc + 2);
    check("stall_launch_delay", 32'(last_interval - i1), 32'd6);
    i2 = last_interval;
    wait_launch(lc + 3);
    check("post_stall_interval", 32'(last_interval), 32'(i1));
    check("stall_interval_grew", 32'(i2 > i1), 32'd1);

    // drop enable in LAT: capture still completes, then the FSM parks
    slave_data = 8'h5a;
    lc = accept_cnt;
    begin
      int t = 0;
      while (accept_cnt == lc && t < 400) begin
        @(posedge clk);
        #2 t++;
      end
      if (accept_cnt == lc) check("accept_timeout", 32'(accept_cnt), 32'(lc + 1));
    end
    enable = 1'b0;
    p0 = polls_done; lc = launch_cnt;
    repeat (100) @(posedge clk);
    check("parked_capture", 32'(polls_done), 32'(p0 + 1));
    check("parked_no_launch", 32'(launch_cnt), 32'(lc));
    check("parked_no_read", 32'(avm_read), 32'd0);
    @(negedge clk);
    enable = 1'b1; c0 = cyc;
    wait_launch(lc + 1);
    check("reenable_delay", 32'(last_launch - c0), 32'(POLL_PERIOD));

    // reset while a stalled read is pending
    stall_left = 1000;
    lc = launch_cnt;
    wait_launch(lc + 1);
    @(negedge clk);
    #3 reset_n = 1'b0;
    #1 check_outputs_reset("async_reset");
    stall_left = 0;
    avm_waitrequest = 1'b0;
    model_reset();
    chg0 = change_cnt;
    repeat (2) @(posedge clk);
    @(negedge clk) reset_n = 1'b1;
    slave_data = 8'h09;
    wait_polls(4);
    check("post_reset_valid",  32'(sw_valid),  32'd1);
    check("post_reset_stable", 32'(sw_stable), 32'h09);
    check("post_reset_nochg",  32'(change_cnt), 32'(chg0));

    repeat (4) @(posedge clk);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
